// File: rtl/nibble_add_scheduler.sv
// -----------------------------------------------------------------------------
// nibble_add_scheduler
//
// Shares one external 4-bit adder slice between two requesters. A granted
// operation is a (4*NIBBLES)-bit unsigned add run one nibble per cycle, from
// the least-significant nibble upwards. The carry is passed from one nibble
// to the next through r_carry. The block assembles the full sum and reports
// the final carry-out as unsigned overflow.
//
// Sequence per operation: IDLE -> LOAD (gnt pulse) -> RUN (NIBBLES cycles)
// -> DONE (done pulse) -> IDLE. If both requests are high in IDLE, the grant
// alternates between the two requesters (round-robin).
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   reqN              request from requester N (N = 0, 1)
//   aN, bN, cinN      operands and carry-in, sampled at the end of the gnt cycle
//   gntN              one-cycle grant pulse (LOAD state)
//   doneN             one-cycle completion pulse (DONE state)
//   result, overflow  sum and carry-out of the top nibble; valid while doneN=1
//   owner             requester currently or most recently granted
//   busy              high in LOAD, RUN and DONE
//   add_a, add_b      operand nibbles to the external adder (0 outside RUN)
//   add_cin           carry-in to the external adder (0 outside RUN)
//   add_sum, add_cout combinational sum and carry-out from the external adder
// -----------------------------------------------------------------------------
module nibble_add_scheduler #(
  parameter int NIBBLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0,
  input  logic [4*NIBBLES-1:0]   a0,
  input  logic [4*NIBBLES-1:0]   b0,
  input  logic                   cin0,
  output logic                   gnt0,
  output logic                   done0,
  input  logic                   req1,
  input  logic [4*NIBBLES-1:0]   a1,
  input  logic [4*NIBBLES-1:0]   b1,
  input  logic                   cin1,
  output logic                   gnt1,
  output logic                   done1,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   overflow,
  output logic                   owner,
  output logic                   busy,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_owner;
  logic               r_last_owner;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [W-1:0]       r_sha;
  logic [W-1:0]       r_shb;
  logic [W-1:0]       r_result;
  logic               r_overflow;

  logic               w_grant;
  logic               w_sel;
  logic               w_last;

  assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves one unassigned; an unassigned path would infer a latch.
    w_next  = r_state;
    w_grant = 1'b0;
    w_sel   = r_owner;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    done0   = 1'b0;
    done1   = 1'b0;
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (req0 && req1) begin
          // Tie: give it to whoever did not go last.
          w_grant = 1'b1;
          w_sel   = ~r_last_owner;
        end else if (req0) begin
          w_grant = 1'b1;
          w_sel   = 1'b0;
        end else if (req1) begin
          w_grant = 1'b1;
          w_sel   = 1'b1;
        end
        if (w_grant) begin
          w_next = S_LOAD;
        end
      end

      S_LOAD: begin
        gnt0   = ~r_owner;
        gnt1   = r_owner;
        w_next = S_RUN;
      end

      S_RUN: begin
        add_a   = r_sha[4*r_idx +: 4];
        add_b   = r_shb[4*r_idx +: 4];
        add_cin = r_carry;
        if (w_last) begin
          w_next = S_DONE;
        end
      end

      S_DONE: begin
        done0  = ~r_owner;
        done1  = r_owner;
        w_next = S_IDLE;
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control and result registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples values from before the edge regardless of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_idx        <= '0;
      r_carry      <= 1'b0;
      r_result     <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner <= w_sel;
          end
        end
        S_LOAD: begin
          r_carry <= r_owner ? cin1 : cin0;
          r_idx   <= '0;
        end
        S_RUN: begin
          r_result[4*r_idx +: 4] <= add_sum;
          r_carry                <= add_cout;
          r_idx                  <= r_idx + 1'b1;
          if (w_last) begin
            r_overflow <= add_cout;
          end
        end
        S_DONE: begin
          r_last_owner <= r_owner;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Operand shadow registers
  // ---------------------------------------------------------------------------
  // NOTE: the shadows are always written in LOAD before RUN reads them, and
  // they never reach an output outside RUN, so they carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD) begin
      r_sha <= r_owner ? a1 : a0;
      r_shb <= r_owner ? b1 : b0;
    end
  end

  assign result   = r_result;
  assign overflow = r_overflow;
  assign owner    = r_owner;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_nibble_add_scheduler.sv
// -----------------------------------------------------------------------------
// tb_nibble_add_scheduler
//
// Directed bench for nibble_add_scheduler with the default 16 nibbles. An
// ideal 4-bit adder is modelled here as the external slice. A table of
// single-requester operations with hand-computed sums is applied in a loop.
// Hand-written sequences then cover reset in the middle of RUN, round-robin
// with both requests held, and back-to-back service of one requester.
// -----------------------------------------------------------------------------
module tb_nibble_add_scheduler;

  localparam int NIB = 16;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [63:0] a0, b0, a1, b1;
  logic        cin0, cin1;
  logic        gnt0, gnt1, done0, done1;
  logic [63:0] result;
  logic        overflow, owner, busy;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int n_cmp;
  int n_fail;

  // Ideal external adder slice.
  logic [4:0] w_add;
  assign w_add    = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
  assign add_sum  = w_add[3:0];
  assign add_cout = w_add[4];

  nibble_add_scheduler #(.NIBBLES(NIB)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .a0       (a0),
    .b0       (b0),
    .cin0     (cin0),
    .gnt0     (gnt0),
    .done0    (done0),
    .req1     (req1),
    .a1       (a1),
    .b1       (b1),
    .cin1     (cin1),
    .gnt1     (gnt1),
    .done1    (done1),
    .result   (result),
    .overflow (overflow),
    .owner    (owner),
    .busy     (busy),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          r;        // requester index
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] exp_res;
    logic        exp_ovf;
    int          seq;      // 0: none, 1: add_cin high every RUN cycle, 2: F+1 nibble pattern
  } vec_t;

  vec_t vecs[8];

  // Adder port values seen in each RUN cycle of the last run_op.
  logic [3:0] cap_a[NIB];
  logic [3:0] cap_b[NIB];
  logic       cap_cin[NIB];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic drive_req(input int r, input logic v, input logic [63:0] a,
                           input logic [63:0] b, input logic cin);
    if (r == 0) begin
      req0 = v; a0 = a; b0 = b; cin0 = cin;
    end else begin
      req1 = v; a1 = a; b1 = b; cin1 = cin;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gnt"},      {62'b0, gnt1, gnt0}, 64'h0);
    check({tag, " done"},     {62'b0, done1, done0}, 64'h0);
    check({tag, " busy"},     {63'b0, busy}, 64'h0);
    check({tag, " result"},   result, 64'h0);
    check({tag, " overflow"}, {63'b0, overflow}, 64'h0);
    check({tag, " owner"},    {63'b0, owner}, 64'h0);
    check({tag, " add_ab"},   {56'b0, add_a, add_b}, 64'h0);
    check({tag, " add_cin"},  {63'b0, add_cin}, 64'h0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete operation for a single requester; all sampling on negedges.
  task automatic run_op(input int r, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic [63:0] exp_res,
                        input logic exp_ovf, input string tag);
    bit got;
    int cyc;
    got = 1'b0;
    drive_req(r, 1'b1, a, b, cin);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      fail_now({tag, " gnt wait"});
      drive_req(r, 1'b0, a, b, cin);
      return;
    end
    check({tag, " gnt"},   {62'b0, gnt1, gnt0}, (r == 0) ? 64'h1 : 64'h2);
    check({tag, " owner"}, {63'b0, owner}, r[63:0]);
    check({tag, " busy"},  {63'b0, busy}, 64'h1);
    // Drop the request; operands stay put until the LOAD edge has passed.
    if (r == 0) req0 = 1'b0; else req1 = 1'b0;

    got = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      cyc = i;
      if (i <= NIB) begin
        cap_a[i-1]   = add_a;
        cap_b[i-1]   = add_b;
        cap_cin[i-1] = add_cin;
      end
      // Operands are no longer sampled; corrupt them to expose late reads.
      if (i == 1) drive_req(r, 1'b0, ~a, ~b, ~cin);
      if (done0 || done1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      fail_now({tag, " done wait"});
      return;
    end
    check({tag, " latency"},  cyc[63:0], 64'd17);
    check({tag, " done"},     {62'b0, done1, done0}, (r == 0) ? 64'h1 : 64'h2);
    check({tag, " result"},   result, exp_res);
    check({tag, " overflow"}, {63'b0, overflow}, {63'b0, exp_ovf});
    @(negedge clk);
    check({tag, " idle after"}, {61'b0, busy, done1, done0}, 64'h0);
  endtask

  initial begin
    int   ng, nd, last_t, idle_cnt;
    bit   saw_done;
    logic [63:0] exp_r;
    logic        exp_o;

    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    req0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0;
    req1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

    //        r  a                       b                       cin  result                  ovf seq
    vecs[0] = '{0, 64'h0123456789ABCDEF, 64'h1111111111111111, 1'b0, 64'h123456789ABCDF00, 1'b0, 0};
    vecs[1] = '{1, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 1'b1, 64'h0000000000000000, 1'b1, 1};
    vecs[2] = '{0, 64'h000000000000000F, 64'h0000000000000001, 1'b0, 64'h0000000000000010, 1'b0, 2};
    vecs[3] = '{1, 64'h8000000000000000, 64'h8000000000000000, 1'b0, 64'h0000000000000000, 1'b1, 0};
    vecs[4] = '{0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 0};
    vecs[5] = '{1, 64'h00000000FFFFFFFF, 64'h0000000000000001, 1'b0, 64'h0000000100000000, 1'b0, 0};
    vecs[6] = '{0, 64'h7FFFFFFFFFFFFFFF, 64'h0000000000000000, 1'b1, 64'h8000000000000000, 1'b0, 0};
    vecs[7] = '{1, 64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 1'b0, 64'h2222222222222211, 1'b0, 0};

    // ---- Reset state ----
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post-reset idle");

    // ---- Table of single-requester operations ----
    for (int v = 0; v < 8; v++) begin
      run_op(vecs[v].r, vecs[v].a, vecs[v].b, vecs[v].cin,
             vecs[v].exp_res, vecs[v].exp_ovf, $sformatf("vec%0d", v));
      if (vecs[v].seq == 1) begin
        for (int i = 0; i < NIB; i++)
          check($sformatf("vec%0d add_cin[%0d]", v, i), {63'b0, cap_cin[i]}, 64'h1);
      end else if (vecs[v].seq == 2) begin
        for (int i = 0; i < NIB; i++) begin
          check($sformatf("vec%0d add_a[%0d]", v, i), {60'b0, cap_a[i]},
                (i == 0) ? 64'hF : 64'h0);
          check($sformatf("vec%0d add_b[%0d]", v, i), {60'b0, cap_b[i]},
                (i == 0) ? 64'h1 : 64'h0);
          check($sformatf("vec%0d add_cin[%0d]", v, i), {63'b0, cap_cin[i]},
                (i == 1) ? 64'h1 : 64'h0);
        end
      end
    end

    // ---- Reset in the middle of RUN at idx=8 ----
    begin
      bit got;
      got = 1'b0;
      drive_req(1, 1'b1, vecs[7].a, vecs[7].b, vecs[7].cin);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (gnt1) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) fail_now("midrun gnt wait");
      req1 = 1'b0;
      repeat (9) @(negedge clk);
      check("midrun idx8 add_a", {60'b0, add_a}, 64'h8);
      check("midrun owner before", {63'b0, owner}, 64'h1);
      rst = 1'b1;
      #1;
      check_all_zero("midrun reset");
      saw_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done0 || done1) saw_done = 1'b1;
      end
      rst = 1'b0;
      check("midrun no done", {63'b0, saw_done}, 64'h0);
      run_op(0, vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].exp_res,
             vecs[0].exp_ovf, "after reset");
    end

    // ---- Both requests held from reset: round-robin 0,1,0,1 ----
    drive_req(0, 1'b1, vecs[0].a, vecs[0].b, vecs[0].cin);
    drive_req(1, 1'b1, vecs[1].a, vecs[1].b, vecs[1].cin);
    apply_reset();
    ng = 0; nd = 0; last_t = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        ng++;
        check($sformatf("rr gnt#%0d who", ng), {62'b0, gnt1, gnt0},
              (ng % 2 == 1) ? 64'h1 : 64'h2);
        if (ng > 1) check($sformatf("rr gnt#%0d spacing", ng), 64'(t - last_t), 64'd19);
        last_t = t;
        if (ng == 4) begin
          req0 = 1'b0;
          req1 = 1'b0;
        end
      end
      if (done0 || done1) begin
        nd++;
        exp_r = (nd % 2 == 1) ? vecs[0].exp_res : vecs[1].exp_res;
        exp_o = (nd % 2 == 1) ? vecs[0].exp_ovf : vecs[1].exp_ovf;
        check($sformatf("rr done#%0d who", nd), {62'b0, done1, done0},
              (nd % 2 == 1) ? 64'h1 : 64'h2);
        check($sformatf("rr done#%0d result", nd), result, exp_r);
        check($sformatf("rr done#%0d overflow", nd), {63'b0, overflow}, {63'b0, exp_o});
        if (nd == 4) break;
      end
    end
    if (nd != 4) fail_now("rr done count");

    // ---- req0 held alone: back-to-back every 19 cycles ----
    drive_req(0, 1'b1, vecs[6].a, vecs[6].b, vecs[6].cin);
    ng = 0; nd = 0; last_t = 0; idle_cnt = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!busy) idle_cnt++;
      if (gnt0 || gnt1) begin
        ng++;
        check($sformatf("b2b gnt#%0d who", ng), {62'b0, gnt1, gnt0}, 64'h1);
        if (ng > 1) begin
          check($sformatf("b2b gnt#%0d spacing", ng), 64'(t - last_t), 64'd19);
          check($sformatf("b2b gnt#%0d idle cycles", ng), 64'(idle_cnt), 64'd1);
        end
        last_t   = t;
        idle_cnt = 0;
        if (ng == 3) req0 = 1'b0;
      end
      if (done0 || done1) begin
        nd++;
        check($sformatf("b2b done#%0d who", nd), {62'b0, done1, done0}, 64'h1);
        check($sformatf("b2b done#%0d result", nd), result, vecs[6].exp_res);
        if (nd == 3) break;
      end
    end
    if (nd != 3) fail_now("b2b done count");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
